// File: rtl/i2c_cfg_master.sv
// Single-byte I2C initiator for the I2S clock-config slave; drives SCL/SDA open-drain from mclk.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_cfg_master #(
  parameter int QTR_DIV = 4
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       scl_oe,
  input  logic       scl_in,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] QTR_LAST = CW'(QTR_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_DACK, S_RDATA, S_MNACK, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   qCnt_q, qCnt_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            nack_q, nack_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            sdaPrev_q;
  logic            stall, qtrEnd, phaseEnd, samplePt, txBit;
  logic [7:0]      addrByte;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low after we released it freezes the quarter counter.
  assign stall = busy && (quarter_q == 2'd2) && !scl_in;
`else
  logic unusedSclIn;
  assign unusedSclIn = scl_in;
  assign stall = 1'b0;
`endif

  assign addrByte = {addr_q, rw_q};
  assign qtrEnd   = (qCnt_q == QTR_LAST) && !stall;
  assign phaseEnd = qtrEnd && (quarter_q == 2'd3);
  assign samplePt = qtrEnd && (quarter_q == 2'd2);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      qCnt_q    <= '0;
      quarter_q <= 2'd0;
      bitCnt_q  <= 3'd0;
      addr_q    <= 7'h00;
      rw_q      <= 1'b0;
      wdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      hold_q    <= 8'h00;
      rdata_q   <= 8'h00;
      done_q    <= 1'b0;
      sdaPrev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qCnt_q    <= qCnt_d;
      quarter_q <= quarter_d;
      bitCnt_q  <= bitCnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      nack_q    <= nack_d;
      hold_q    <= hold_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      sdaPrev_q <= sda_oe;
    end
  end

  always_comb begin
    state_d   = state_q;
    qCnt_d    = qCnt_q;
    quarter_d = quarter_q;
    bitCnt_d  = bitCnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    nack_d    = nack_q;
    hold_d    = hold_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE) begin
      qCnt_d    = '0;
      quarter_d = 2'd0;
      bitCnt_d  = 3'd0;
      if (start) begin
        addr_d  = addr;
        rw_d    = rw;
        wdata_d = wdata;
        nack_d  = 1'b0;
        state_d = S_START;
      end
    end else begin
      if (qtrEnd) begin
        qCnt_d    = '0;
        quarter_d = quarter_q + 2'd1;
      end else if (!stall) begin
        qCnt_d = qCnt_q + CW'(1);
      end
      if (samplePt) begin
        case (state_q)
          S_AACK:  nack_d = sda_in;
          S_DACK:  if (sda_in) nack_d = 1'b1;
          S_RDATA: hold_d = {hold_q[6:0], sda_in};
          default: ;
        endcase
      end
      if (phaseEnd) begin
        case (state_q)
          S_START: state_d = S_ADDR;
          S_ADDR: begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_d = S_AACK;
          end
          S_AACK: begin
            if (nack_q)    state_d = S_STOP;
            else if (rw_q) state_d = S_RDATA;
            else           state_d = S_WDATA;
          end
          S_WDATA: begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_d = S_DACK;
          end
          S_DACK: state_d = S_STOP;
          S_RDATA: begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_d = S_MNACK;
          end
          S_MNACK: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (rw_q && !nack_q) rdata_d = hold_q;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // In a bit slot SDA keeps its previous level through q0 and only changes once SCL has been low a quarter.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = done_q;
    nack   = nack_q;
    rdata  = rdata_q;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    txBit  = 1'b1;
    case (state_q)
      S_ADDR:  txBit = addrByte[3'd7 - bitCnt_q];
      S_WDATA: txBit = wdata_q[3'd7 - bitCnt_q];
      default: txBit = 1'b1;
    endcase
    case (state_q)
      S_START: sda_oe = quarter_q[1];
      S_ADDR, S_AACK, S_WDATA, S_DACK, S_RDATA, S_MNACK: begin
        scl_oe = ~quarter_q[1];
        sda_oe = (quarter_q == 2'd0) ? sdaPrev_q : ~txBit;
      end
      S_STOP: begin
        scl_oe = ~quarter_q[1];
        sda_oe = (quarter_q != 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Scoreboard bench for i2c_cfg_master with a behavioural config slave at address 7'h41.
// Build with I2C_CLK_STRETCH_EN defined to expect the stretched timing.
module tb_i2c_cfg_master;

  localparam int QTR = 4;
  localparam int FULL_LAT = 80 * QTR;
  localparam int NACK_LAT = (1 + 8 + 1 + 1) * 4 * QTR;
  localparam logic [6:0] SLV_ADDR = 7'h41;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 37;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       mclk = 1'b0;
  logic       reset, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, nack, scl_oe, sda_oe;
  logic [7:0] rdata;
  logic       sclPad, sdaPad;
  logic       slvSda = 1'b0;
  logic       sclHold = 1'b0;

  assign sclPad = ~(scl_oe | sclHold);
  assign sdaPad = ~(sda_oe | slvSda);

  i2c_cfg_master #(.QTR_DIV(QTR)) dut (
    .mclk(mclk), .reset(reset), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .busy(busy), .done(done), .nack(nack), .rdata(rdata),
    .scl_oe(scl_oe), .scl_in(sclPad), .sda_oe(sda_oe), .sda_in(sdaPad)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          doneCyc;
    logic        expNack;
    logic [7:0]  expRdata;
    int          bitCnt;
    logic [31:0] bits;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   doneCount = 0;
  logic [7:0] expRd = 8'h00;

  int          capCnt = 0;
  logic [31:0] capBits = '0;
  logic        pending = 1'b0, pendBit = 1'b0;
  logic        prevScl = 1'b1, prevSda = 1'b1;
  logic        matched = 1'b0, rdMode = 1'b0;
  logic        stretchArm = 1'b0;
  int          holdCnt = 0;
  logic [7:0]  rdByte = 8'hA5;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Slave model: decodes bits from SCL edges, ACKs its own address, serves rdByte on reads,
  // and can stretch SCL for 37 mclk when the master releases it in address slot 2.
  always @(negedge mclk) begin
    logic sclM, sdaNow;
    sclM   = ~scl_oe;
    sdaNow = sdaPad;
    if (holdCnt > 0) begin
      holdCnt--;
      if (holdCnt == 0) sclHold = 1'b0;
    end
    if (prevScl && sclM && prevSda && !sdaNow) begin
      capCnt = 0; capBits = '0; pending = 1'b0; matched = 1'b0; rdMode = 1'b0; slvSda = 1'b0;
    end else if (prevScl && sclM && !prevSda && sdaNow) begin
      pending = 1'b0; slvSda = 1'b0;
    end else if (!prevScl && sclM) begin
      pending = 1'b1;
      pendBit = sdaNow;
      if (stretchArm && capCnt == 2) begin
        stretchArm = 1'b0; holdCnt = 37; sclHold = 1'b1;
      end
    end else if (prevScl && !sclM) begin
      if (pending) begin
        capBits = {capBits[30:0], pendBit};
        capCnt++;
        pending = 1'b0;
      end
      if (capCnt == 8) begin
        matched = (capBits[7:1] == SLV_ADDR);
        rdMode  = capBits[0];
      end
      slvSda = 1'b0;
      if (matched) begin
        if (capCnt == 8) slvSda = 1'b1;
        else if (rdMode && capCnt >= 9 && capCnt <= 16) slvSda = ~rdByte[16 - capCnt];
        else if (!rdMode && capCnt == 17) slvSda = 1'b1;
      end
    end
    prevScl = sclM;
    prevSda = sdaNow;
  end

  // Scoreboard monitor: every done pulse is matched against the oldest queued expectation.
  always @(negedge mclk) begin
    if (done === 1'b1) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({e.name, " done_cycle"}, cyc, e.doneCyc);
        checkOutput({e.name, " nack"}, {31'd0, nack}, {31'd0, e.expNack});
        checkOutput({e.name, " rdata"}, {24'd0, rdata}, {24'd0, e.expRdata});
        checkOutput({e.name, " bit_count"}, capCnt, e.bitCnt);
        checkOutput({e.name, " bits"}, capBits, e.bits);
      end
    end
  end

  task automatic applyStimulus(input string nm, input logic [6:0] a, input logic r,
                               input logic [7:0] w, input bit pushExp, input logic expNack,
                               input int nBits, input logic [31:0] bits, input int lat,
                               output int startCyc);
    exp_t e;
    @(negedge mclk);
    addr = a; rw = r; wdata = w; start = 1'b1;
    @(posedge mclk);
    #1;
    start = 1'b0;
    startCyc = cyc;
    checkOutput({nm, " busy_after_start"}, {31'd0, busy}, 32'd1);
    if (pushExp) begin
      if (r && !expNack) expRd = rdByte;
      e.name = nm; e.doneCyc = startCyc + lat; e.expNack = expNack;
      e.expRdata = expRd; e.bitCnt = nBits; e.bits = bits;
      expQ.push_back(e);
    end
  endtask

  task automatic waitForDone(input string nm, input int target);
    int i;
    for (i = 0; i < 3000 && doneCount < target; i++) @(negedge mclk);
    if (doneCount < target) checkOutput({nm, " done_timeout"}, doneCount, target);
    @(negedge mclk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sc, base;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    repeat (3) @(negedge mclk);
    checkOutput("reset scl_oe", {31'd0, scl_oe}, 32'd0);
    checkOutput("reset sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset nack", {31'd0, nack}, 32'd0);
    checkOutput("reset rdata", {24'd0, rdata}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge mclk);

    base = doneCount;
    applyStimulus("S1_write", 7'h41, 1'b0, 8'h03, 1'b1, 1'b0, 18,
                  32'({7'h41, 1'b0, 1'b0, 8'h03, 1'b0}), FULL_LAT, sc);
    waitForDone("S1_write", base + 1);

    base = doneCount;
    applyStimulus("S2_noack", 7'h22, 1'b0, 8'h55, 1'b1, 1'b1, 9,
                  32'({7'h22, 1'b0, 1'b1}), NACK_LAT, sc);
    waitForDone("S2_noack", base + 1);

    base = doneCount;
    applyStimulus("S3_read", 7'h41, 1'b1, 8'h00, 1'b1, 1'b0, 18,
                  32'({7'h41, 1'b1, 1'b0, 8'hA5, 1'b1}), FULL_LAT, sc);
    waitForDone("S3_read", base + 1);

    base = doneCount;
    applyStimulus("S4_busy_start", 7'h41, 1'b0, 8'h5A, 1'b1, 1'b0, 18,
                  32'({7'h41, 1'b0, 1'b0, 8'h5A, 1'b0}), FULL_LAT, sc);
    repeat (50) @(negedge mclk);
    addr = 7'h22; wdata = 8'hFF; rw = 1'b1; start = 1'b1;
    @(posedge mclk);
    #1;
    start = 1'b0;
    waitForDone("S4_busy_start", base + 1);
    repeat (30) @(negedge mclk);
    checkOutput("S4 single_done", doneCount, base + 1);

    base = doneCount;
    applyStimulus("S5_reset", 7'h41, 1'b0, 8'hC3, 1'b0, 1'b0, 0, 32'd0, 0, sc);
    for (int i = 0; i < 1000 && cyc != sc + 52 * QTR + 6; i++) @(negedge mclk);
    checkOutput("S5 scl_held_before_reset", {31'd0, scl_oe}, 32'd1);
    checkOutput("S5 sda_held_before_reset", {31'd0, sda_oe}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("S5 scl_released", {31'd0, scl_oe}, 32'd0);
    checkOutput("S5 sda_released", {31'd0, sda_oe}, 32'd0);
    checkOutput("S5 busy_cleared", {31'd0, busy}, 32'd0);
    checkOutput("S5 rdata_cleared", {24'd0, rdata}, 32'd0);
    expRd = 8'h00;
    repeat (2) @(negedge mclk);
    reset = 1'b0;
    repeat (400) @(negedge mclk);
    checkOutput("S5 no_done_after_reset", doneCount, base);

    base = doneCount;
    applyStimulus("S5_restart", 7'h41, 1'b0, 8'h81, 1'b1, 1'b0, 18,
                  32'({7'h41, 1'b0, 1'b0, 8'h81, 1'b0}), FULL_LAT, sc);
    waitForDone("S5_restart", base + 1);

    base = doneCount;
    stretchArm = 1'b1;
    applyStimulus("S6_stretch", 7'h41, 1'b0, 8'h03, 1'b1, 1'b0, 18,
                  32'({7'h41, 1'b0, 1'b0, 8'h03, 1'b0}), FULL_LAT + STRETCH_EXTRA, sc);
    waitForDone("S6_stretch", base + 1);

    repeat (10) @(negedge mclk);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
